i2c_write_sequencer: RTL and testbench

- Frame-level controller that drives the team's byte-level I2C master (`start`/`stop`/`i2c_en`/`tx_data` out; `ready`/`tx_done` in).
- Accepts a write-frame request: 7-bit slave address plus 1..MAX_LEN payload bytes streamed on a valid/ready byte port.
- Sequences START, address byte, payload bytes and STOP, then reports done or error.
- Sits between register-programming logic (e.g. camera/sensor configuration) and the I2C master.

---
 rtl/i2c_seq_pkg.sv | 38 +++
 rtl/i2c_seq_watchdog.sv | 46 ++++
 rtl/i2c_write_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_i2c_write_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// ---------------------------------------------------------------------------
// i2c_seq_pkg
// Shared definitions for the I2C write-frame sequencer:
//   - seq_state_e     : sequencer FSM state encoding
//   - I2C_WRITE_BIT   : R/W bit appended to the 7-bit slave address (write)
//   - MAX_LEN_DEF     : default maximum payload bytes per frame
//   - TIMEOUT_CYC_DEF : default watchdog limit in clk cycles
//   - is_wait_state() : true for states that wait on the byte-level master
// ---------------------------------------------------------------------------
package i2c_seq_pkg;

    localparam int   MAX_LEN_DEF     = 16;
    localparam int   TIMEOUT_CYC_DEF = 200000;
    localparam logic I2C_WRITE_BIT   = 1'b0;

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_START        = 4'd1,
        S_WAIT_LO      = 4'd2,
        S_WAIT_HOLD    = 4'd3,
        S_LOAD         = 4'd4,
        S_WAIT_TXD     = 4'd5,
        S_WAIT_ACK     = 4'd6,
        S_FETCH        = 4'd7,
        S_STOP         = 4'd8,
        S_WAIT_STOP_LO = 4'd9,
        S_WAIT_IDLE    = 4'd10
    } seq_state_e;

    // States in which the sequencer is waiting on the master. S_FETCH is
    // deliberately absent: an upstream stall there is legal bus stretching.
    function automatic logic is_wait_state(input seq_state_e s);
        return (s == S_WAIT_LO)   || (s == S_WAIT_HOLD)    ||
               (s == S_WAIT_TXD)  || (s == S_WAIT_ACK)     ||
               (s == S_WAIT_STOP_LO) || (s == S_WAIT_IDLE);
    endfunction

endpackage

// File: rtl/i2c_seq_watchdog.sv
// ---------------------------------------------------------------------------
// i2c_seq_watchdog
// Cycle counter that flags a stuck wait state.
//   clk        in  system clock
//   reset      in  asynchronous, active-high reset
//   en_i       in  count this cycle (sequencer is in a wait state)
//   clr_i      in  restart from zero (sequencer changes state)
//   expired_o  out counter has reached TIMEOUT_CYC-1 while enabled
// Only instantiated when I2C_SEQ_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module i2c_seq_watchdog #(
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Outside wait states the count is held at zero so every wait starts fresh.
    always_comb begin
        count_d = count_q;
        if (clr_i || !en_i) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = en_i && (count_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/i2c_write_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_write_sequencer
// Frame-level controller in front of the byte-level I2C master. Accepts a
// write request (7-bit address + 1..MAX_LEN payload bytes streamed on a
// valid/ready port) and sequences START, address byte, payload and STOP.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready        frame request handshake (ready only in idle)
//   req_addr[6:0], req_len     slave address and payload byte count
//   data_valid/data_ready/data_in  payload byte stream (ready = 1-cycle pulse)
//   busy, done, err            frame status; done/err are 1-cycle pulses
//   m_start, m_stop, m_i2c_en, m_tx_data   commands to the master
//   m_ready, m_tx_done         status from the master
//
// Build option
//   I2C_SEQ_TIMEOUT_EN : adds a watchdog that aborts (err pulse, back to
//                        idle) after TIMEOUT_CYC cycles in any wait state.
//                        Without it the wait states wait forever.
// ---------------------------------------------------------------------------
module i2c_write_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int MAX_LEN     = MAX_LEN_DEF,
    parameter int LEN_W       = $clog2(MAX_LEN + 1),
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [6:0]       req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic [7:0]       data_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             m_start,
    output logic             m_stop,
    output logic             m_i2c_en,
    output logic [7:0]       m_tx_data,
    input  logic             m_ready,
    input  logic             m_tx_done
);

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("i2c_write_sequencer: TIMEOUT_CYC must be at least 2");
    end
    if (MAX_LEN < 1) begin : g_bad_max_len
        $error("i2c_write_sequencer: MAX_LEN must be at least 1");
    end

    seq_state_e       state_q, state_d;
    logic [6:0]       addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             len_bad_q, len_bad_d;
    logic [LEN_W-1:0] bytes_sent_q, bytes_sent_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_done_prev_q;

    logic accept;
    logic fetch_take;
    logic tx_done_rise;
    logic wd_expired;

    assign accept       = req_valid && (state_q == S_IDLE);
    assign fetch_take   = (state_q == S_FETCH) && data_valid;
    // m_tx_done stays high until the next byte is loaded, so only its
    // rising edge marks the end of the byte currently being shifted.
    assign tx_done_rise = m_tx_done && !tx_done_prev_q;

`ifdef I2C_SEQ_TIMEOUT_EN
    logic wd_en;
    logic wd_clr;

    assign wd_en  = is_wait_state(state_q);
    assign wd_clr = (state_d != state_q);

    i2c_seq_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .en_i      (wd_en),
        .clr_i     (wd_clr),
        .expired_o (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:         if (req_valid) state_d = S_START;
            // A bad length is reported from S_START without touching the bus.
            S_START:        state_d = len_bad_q ? S_IDLE : S_WAIT_LO;
            S_WAIT_LO:      if (!m_ready) state_d = S_WAIT_HOLD;
            S_WAIT_HOLD:    if (m_ready) state_d = S_LOAD;
            S_LOAD:         state_d = S_WAIT_TXD;
            S_WAIT_TXD:     if (tx_done_rise) state_d = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (m_ready) begin
                    state_d = (bytes_sent_q == len_q) ? S_STOP : S_FETCH;
                end
            end
            S_FETCH:        if (data_valid) state_d = S_LOAD;
            S_STOP:         state_d = S_WAIT_STOP_LO;
            S_WAIT_STOP_LO: if (!m_ready) state_d = S_WAIT_IDLE;
            S_WAIT_IDLE:    if (m_ready) state_d = S_IDLE;
            default:        state_d = S_IDLE;
        endcase
        // The watchdog abort overrides whatever the wait state would do.
        if (wd_expired) begin
            state_d = S_IDLE;
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        req_ready  = 1'b0;
        data_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        m_start    = 1'b0;
        m_stop     = 1'b0;
        m_i2c_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
            end
            S_START: begin
                if (len_bad_q) begin
                    err = 1'b1;
                end else begin
                    busy     = 1'b1;
                    m_start  = 1'b1;
                    m_i2c_en = 1'b1;
                end
            end
            S_LOAD: begin
                busy     = 1'b1;
                m_i2c_en = 1'b1;
            end
            S_FETCH: begin
                busy       = 1'b1;
                data_ready = data_valid;
            end
            S_STOP: begin
                busy     = 1'b1;
                m_stop   = 1'b1;
                m_i2c_en = 1'b1;
            end
            S_WAIT_IDLE: begin
                // busy drops in the same cycle as the done pulse.
                busy = !m_ready;
                done = m_ready;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
        if (wd_expired) begin
            busy = 1'b0;
            done = 1'b0;
            err  = 1'b1;
        end
    end

    // ------------------------------------------------------------- datapath
    always_comb begin
        addr_d       = addr_q;
        len_d        = len_q;
        len_bad_d    = len_bad_q;
        bytes_sent_d = bytes_sent_q;
        tx_data_d    = tx_data_q;
        if (accept) begin
            addr_d       = req_addr;
            len_d        = req_len;
            len_bad_d    = (req_len == '0) || (req_len > LEN_W'(MAX_LEN));
            bytes_sent_d = '0;
        end
        // Address byte is staged while waiting for HOLD so it is stable
        // during the S_LOAD cycle in which the master samples it.
        if ((state_q == S_WAIT_HOLD) && m_ready && !wd_expired) begin
            tx_data_d = {addr_q, I2C_WRITE_BIT};
        end
        if (fetch_take) begin
            tx_data_d    = data_in;
            bytes_sent_d = bytes_sent_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q         <= '0;
            len_q          <= '0;
            len_bad_q      <= 1'b0;
            bytes_sent_q   <= '0;
            tx_data_q      <= 8'h00;
            tx_done_prev_q <= 1'b0;
        end else begin
            addr_q         <= addr_d;
            len_q          <= len_d;
            len_bad_q      <= len_bad_d;
            bytes_sent_q   <= bytes_sent_d;
            tx_data_q      <= tx_data_d;
            tx_done_prev_q <= m_tx_done;
        end
    end

    assign m_tx_data = tx_data_q;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_write_sequencer
// Directed bench for i2c_write_sequencer with a cycle-level model of the
// byte-level I2C master (FCOUNT = 8 clk per bit) and an ACKing slave.
// Honours I2C_SEQ_TIMEOUT_EN for the NACK/watchdog case.
// ---------------------------------------------------------------------------
module tb_i2c_write_sequencer;
    import i2c_seq_pkg::*;

    localparam int MAX_LEN     = 16;
    localparam int LEN_W       = $clog2(MAX_LEN + 1);
    localparam int TIMEOUT_CYC = 1000;
    localparam int FCOUNT      = 8;

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [6:0]       req_addr;
    logic [LEN_W-1:0] req_len;
    logic             data_valid;
    logic             data_ready;
    logic [7:0]       data_in;
    logic             busy;
    logic             done;
    logic             err;
    logic             m_start;
    logic             m_stop;
    logic             m_i2c_en;
    logic [7:0]       m_tx_data;
    logic             m_ready;
    logic             m_tx_done;

    i2c_write_sequencer #(
        .MAX_LEN     (MAX_LEN),
        .LEN_W       (LEN_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data_in    (data_in),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .m_start    (m_start),
        .m_stop     (m_stop),
        .m_i2c_en   (m_i2c_en),
        .m_tx_data  (m_tx_data),
        .m_ready    (m_ready),
        .m_tx_done  (m_tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------- master model
    typedef enum logic [2:0] {M_IDLE, M_START, M_HOLD, M_SHIFT, M_ACK, M_STOP} mst_e;
    mst_e       mst_q;
    int         mcnt;
    int         mbit;
    logic       txd_q;
    logic [7:0] bus_mem [0:63];
    int         bus_cnt;
    int         stop_cnt;
    logic       nack_mode;
    logic       scl_w;

    assign m_ready   = (mst_q == M_IDLE) || (mst_q == M_HOLD);
    assign m_tx_done = txd_q;
    assign scl_w     = (mst_q == M_IDLE) || (mst_q == M_START) || (mst_q == M_STOP) ||
                       (((mst_q == M_SHIFT) || (mst_q == M_ACK)) && (mcnt >= FCOUNT / 2));

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mst_q    <= M_IDLE;
            mcnt     <= 0;
            mbit     <= 0;
            txd_q    <= 1'b0;
            bus_cnt  <= 0;
            stop_cnt <= 0;
        end else begin
            case (mst_q)
                M_IDLE: if (m_i2c_en && m_start) begin mst_q <= M_START; mcnt <= 0; end
                M_START: begin
                    if (mcnt == FCOUNT - 1) mst_q <= M_HOLD;
                    else mcnt <= mcnt + 1;
                end
                M_HOLD: begin
                    if (m_i2c_en && m_stop) begin
                        mst_q <= M_STOP;
                        mcnt  <= 0;
                    end else if (m_i2c_en && !m_start) begin
                        bus_mem[bus_cnt[5:0]] <= m_tx_data;
                        bus_cnt <= bus_cnt + 1;
                        txd_q   <= 1'b0;
                        mbit    <= 0;
                        mcnt    <= 0;
                        mst_q   <= M_SHIFT;
                    end
                end
                M_SHIFT: begin
                    if (mcnt == FCOUNT - 1) begin
                        mcnt <= 0;
                        if (mbit == 7) begin
                            txd_q <= 1'b1;
                            mst_q <= M_ACK;
                        end else begin
                            mbit <= mbit + 1;
                        end
                    end else begin
                        mcnt <= mcnt + 1;
                    end
                end
                M_ACK: begin
                    if (!nack_mode) begin
                        if (mcnt == FCOUNT - 1) begin mst_q <= M_HOLD; mcnt <= 0; end
                        else mcnt <= mcnt + 1;
                    end
                end
                M_STOP: begin
                    if (mcnt == FCOUNT - 1) begin
                        mst_q    <= M_IDLE;
                        stop_cnt <= stop_cnt + 1;
                    end else begin
                        mcnt <= mcnt + 1;
                    end
                end
                default: mst_q <= M_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------ monitor
    int   done_cnt = 0, err_cnt = 0, dr_cnt = 0, start_cnt = 0, both_cnt = 0;
    int   accept_cnt = 0, viol_cnt = 0;
    int   last_done_cyc = 0, last_accept_cyc = 0, last_err_cyc = 0, txd_rise_cyc = 0;
    logic txd_prev_mon = 1'b0;
    logic busy_at_err = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin done_cnt <= done_cnt + 1; last_done_cyc <= cyc; end
            if (err) begin err_cnt <= err_cnt + 1; last_err_cyc <= cyc; busy_at_err <= busy; end
            if (data_ready) dr_cnt <= dr_cnt + 1;
            if (m_start) start_cnt <= start_cnt + 1;
            if (m_start && m_stop) both_cnt <= both_cnt + 1;
            if (req_valid && req_ready) begin accept_cnt <= accept_cnt + 1; last_accept_cyc <= cyc; end
            if (m_i2c_en && (mst_q != M_IDLE) && (mst_q != M_HOLD)) viol_cnt <= viol_cnt + 1;
            if (m_tx_done && !txd_prev_mon) txd_rise_cyc <= cyc;
        end
        txd_prev_mon <= m_tx_done;
    end

    // ----------------------------------------------------------- checking
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [15:0] out_vec;
    assign out_vec = {req_ready, data_ready, busy, done, err, m_start, m_stop, m_i2c_en, m_tx_data};

    logic [7:0] tx_bytes [0:MAX_LEN-1];
    int         stall_viol;

    task automatic request(input logic [6:0] a, input logic [LEN_W-1:0] l, output bit ok);
        @(posedge clk); #1;
        req_addr  = a;
        req_len   = l;
        req_valid = 1'b1;
        ok        = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic feed_bytes(input int len, input int stall_idx, input int stall_cyc);
        bit got;
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            if (i == stall_idx) begin
                for (int c = 0; c < stall_cyc; c++) begin
                    @(negedge clk);
                    if ((c >= 100) && (scl_w || m_i2c_en || !m_ready)) stall_viol++;
                end
                @(posedge clk); #1;
            end
            data_in    = tx_bytes[i];
            data_valid = 1'b1;
            got        = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                if (data_ready) begin got = 1'b1; break; end
            end
            check_eq($sformatf("feed_byte%0d_taken", i), 32'(got), 32'd1);
            @(posedge clk); #1;
            data_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done || err) begin ok = done; break; end
        end
        #1;
    endtask

    bit ok;
    int b_bus, b_done, b_err, b_dr, b_stop, b_start, b_acc, d1;

    task automatic snap();
        b_bus = bus_cnt; b_done = done_cnt; b_err = err_cnt; b_dr = dr_cnt;
        b_stop = stop_cnt; b_start = start_cnt; b_acc = accept_cnt;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
        data_valid = 1'b0; data_in = 8'h00; nack_mode = 1'b0; stall_viol = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outputs", 32'(out_vec), 32'h8000);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single write 0x21, {A5, 3C}
        snap();
        tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h3C;
        request(7'h21, LEN_W'(2), ok);
        check_eq("t1_accept", 32'(ok), 32'd1);
        @(negedge clk);
        check_eq("t1_busy_rdy", 32'({busy, req_ready}), 32'b10);
        feed_bytes(2, -1, 0);
        wait_done(4000, ok);
        check_eq("t1_done_seen", 32'(ok), 32'd1);
        @(posedge clk); #1;
        check_eq("t1_nbytes", 32'(bus_cnt - b_bus), 32'd3);
        check_eq("t1_byte0", 32'(bus_mem[b_bus]), 32'h42);
        check_eq("t1_byte1", 32'(bus_mem[b_bus+1]), 32'hA5);
        check_eq("t1_byte2", 32'(bus_mem[b_bus+2]), 32'h3C);
        check_eq("t1_stops", 32'(stop_cnt - b_stop), 32'd1);
        check_eq("t1_done_cnt", 32'(done_cnt - b_done), 32'd1);
        check_eq("t1_dready_cnt", 32'(dr_cnt - b_dr), 32'd2);
        check_eq("t1_start_cnt", 32'(start_cnt - b_start), 32'd1);
        check_eq("t1_err_cnt", 32'(err_cnt - b_err), 32'd0);
        check_eq("t1_idle_after", 32'({req_ready, busy}), 32'b10);

        // Upstream stall of 500 cycles before payload byte 2
        snap();
        stall_viol = 0;
        tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22;
        request(7'h50, LEN_W'(2), ok);
        feed_bytes(2, 1, 500);
        wait_done(4000, ok);
        check_eq("stall_done_seen", 32'(ok), 32'd1);
        @(posedge clk); #1;
        check_eq("stall_scl_low", 32'(stall_viol), 32'd0);
        check_eq("stall_nbytes", 32'(bus_cnt - b_bus), 32'd3);
        check_eq("stall_byte0", 32'(bus_mem[b_bus]), 32'hA0);
        check_eq("stall_byte1", 32'(bus_mem[b_bus+1]), 32'h11);
        check_eq("stall_byte2", 32'(bus_mem[b_bus+2]), 32'h22);
        check_eq("stall_err_cnt", 32'(err_cnt - b_err), 32'd0);

        // Bad lengths: 0 and MAX_LEN+1
        snap();
        request(7'h21, LEN_W'(0), ok);
        @(negedge clk);
        check_eq("bl0_err_nostart", 32'({err, m_start, m_i2c_en}), 32'b100);
        @(negedge clk);
        check_eq("bl0_ready_back", 32'({req_ready, err}), 32'b10);
        request(7'h21, LEN_W'(MAX_LEN + 1), ok);
        @(negedge clk);
        check_eq("bl17_err_nostart", 32'({err, m_start, m_i2c_en}), 32'b100);
        @(negedge clk);
        check_eq("bl17_ready_back", 32'({req_ready, err}), 32'b10);
        @(posedge clk); #1;
        check_eq("bl_err_cnt", 32'(err_cnt - b_err), 32'd2);
        check_eq("bl_start_cnt", 32'(start_cnt - b_start), 32'd0);
        check_eq("bl_bus_bytes", 32'(bus_cnt - b_bus), 32'd0);

        // Back-to-back: second request held during frame 1
        snap();
        tx_bytes[0] = 8'h5A;
        request(7'h10, LEN_W'(1), ok);
        @(posedge clk); #1;
        req_addr = 7'h11; req_len = LEN_W'(1); req_valid = 1'b1;
        feed_bytes(1, -1, 0);
        wait_done(4000, ok);
        check_eq("b2b_done1", 32'(ok), 32'd1);
        check_eq("b2b_held_off", 32'(accept_cnt - b_acc), 32'd1);
        d1 = last_done_cyc;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("b2b_accept2", 32'(ok), 32'd1);
        check_eq("b2b_accept_cyc", 32'(last_accept_cyc - d1), 32'd1);
        tx_bytes[0] = 8'hC3;
        feed_bytes(1, -1, 0);
        wait_done(4000, ok);
        check_eq("b2b_done2", 32'(ok), 32'd1);
        @(posedge clk); #1;
        check_eq("b2b_bytes", 32'({bus_mem[b_bus], bus_mem[b_bus+1], bus_mem[b_bus+2], bus_mem[b_bus+3]}),
                 32'h205A22C3);
        check_eq("b2b_stops", 32'(stop_cnt - b_stop), 32'd2);

        // Maximum length frame
        snap();
        for (int i = 0; i < MAX_LEN; i++) tx_bytes[i] = 8'(i * 17);
        request(7'h7F, LEN_W'(MAX_LEN), ok);
        feed_bytes(MAX_LEN, -1, 0);
        wait_done(6000, ok);
        check_eq("max_done", 32'(ok), 32'd1);
        @(posedge clk); #1;
        check_eq("max_nbytes", 32'(bus_cnt - b_bus), 32'(MAX_LEN + 1));
        check_eq("max_byte0", 32'(bus_mem[b_bus]), 32'hFE);
        check_eq("max_byte8", 32'(bus_mem[b_bus+8]), 32'h77);
        check_eq("max_last", 32'(bus_mem[b_bus+MAX_LEN]), 32'hFF);
        check_eq("max_dready", 32'(dr_cnt - b_dr), 32'(MAX_LEN));

        // Slave NACKs the address byte
        snap();
        nack_mode = 1'b1;
        request(7'h33, LEN_W'(1), ok);
`ifdef I2C_SEQ_TIMEOUT_EN
        wait_done(3000, ok);
        check_eq("nack_err_cnt", 32'(err_cnt - b_err), 32'd1);
        check_eq("nack_err_delay", 32'(last_err_cyc - txd_rise_cyc), 32'(TIMEOUT_CYC));
        check_eq("nack_busy_at_err", 32'(busy_at_err), 32'd0);
`else
        repeat (1500) @(negedge clk);
        check_eq("nack_busy_held", 32'(busy), 32'd1);
        #1;
        check_eq("nack_no_err", 32'(err_cnt - b_err), 32'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b1; nack_mode = 1'b0;
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;

        // Reset in the middle of payload byte 1
        snap();
        tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h3C;
        request(7'h21, LEN_W'(2), ok);
        feed_bytes(1, -1, 0);
        repeat (20) @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_outputs", 32'(out_vec), 32'h8000);
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
        repeat (5) @(posedge clk); #1;
        check_eq("midrst_no_pulse", 32'((done_cnt - b_done) + (err_cnt - b_err)), 32'd0);

        // Recovery frame after reset
        snap();
        tx_bytes[0] = 8'h81;
        request(7'h00, LEN_W'(1), ok);
        feed_bytes(1, -1, 0);
        wait_done(4000, ok);
        check_eq("rec_done", 32'(ok), 32'd1);
        @(posedge clk); #1;
        check_eq("rec_bytes", 32'({bus_mem[b_bus], bus_mem[b_bus+1]}), 32'h0081);
        check_eq("proto_violations", 32'(viol_cnt), 32'd0);
        check_eq("start_and_stop", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
